clk_reset_ctrl: RTL and testbench

- Sits directly downstream of the system PLL wrapper; runs on the 44 MHz PLL output clock.
- Consumes the PLL lock indication and produces three things for the core:
  - a qualified, glitch-free core reset;
  - derived clock-enable pulses (11 MHz pixel/ALU rate and a slower CPU rate);
  - lock-loss diagnostics.
- Also services the OSD/menu soft-reset request with a guaranteed minimum reset width.

---
 rtl/clk_reset_ctrl.sv | 140 ++++++++++++++
 tb/tb_clk_reset_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_reset_ctrl.sv
// Core reset / clock-enable controller downstream of the PLL: qualifies lock,
// sequences core reset, derives ce_fast/ce_slow and counts lock losses.
module clk_reset_ctrl #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int RESET_HOLD_CYCLES  = 64,
  parameter int CE_DIV             = 4,
  parameter int SLOW_DIV           = 15
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       core_reset,
  output logic       ce_fast,
  output logic       ce_slow,
  output logic [1:0] state,
  output logic [7:0] lock_lost_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int FW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int LW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [FW-1:0] FAST_LAST   = FW'(CE_DIV - 1);
  localparam logic [LW-1:0] SLOW_LAST   = LW'(SLOW_DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [SW-1:0]          stable_q, stable_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [FW-1:0]          fast_q, fast_d;
  logic [LW-1:0]          slow_q, slow_d;
  logic [7:0]             lost_q, lost_d;
  logic                   core_reset_q, core_reset_d;
  logic                   ce_fast_q, ce_fast_d;
  logic                   ce_slow_q, ce_slow_d;
  logic                   locked_s;

  // Only sync_q[0] ever samples the asynchronous pll_locked.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    stable_d = '0;
    hold_d   = '0;
    lost_d   = lost_q;
    case (state_q)
      WAIT_LOCK: if (locked_s) state_d = STABLE;
      STABLE: begin
        if (!locked_s)                state_d = WAIT_LOCK;
        else if (stable_q == STABLE_LAST) state_d = RUN;
        else                          stable_d = stable_q + 1'b1;
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else if (soft_reset) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else if (soft_reset) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Dividers restart from 0 on STABLE entry and go quiet on the edge that
  // enters WAIT_LOCK; HOLD/RUN transitions leave their phase untouched.
  always_comb begin
    fast_d    = '0;
    slow_d    = '0;
    ce_fast_d = 1'b0;
    ce_slow_d = 1'b0;
    if (state_q != WAIT_LOCK && state_d != WAIT_LOCK) begin
      fast_d    = (fast_q == FAST_LAST) ? '0 : fast_q + 1'b1;
      slow_d    = slow_q;
      if (ce_fast_q) slow_d = (slow_q == SLOW_LAST) ? '0 : slow_q + 1'b1;
      ce_fast_d = (fast_d == FAST_LAST);
      ce_slow_d = ce_fast_d && (slow_d == SLOW_LAST);
    end
  end

  assign core_reset_d = (state_d != RUN);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= WAIT_LOCK;
      stable_q     <= '0;
      hold_q       <= '0;
      fast_q       <= '0;
      slow_q       <= '0;
      lost_q       <= '0;
      core_reset_q <= 1'b1;
      ce_fast_q    <= 1'b0;
      ce_slow_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      stable_q     <= stable_d;
      hold_q       <= hold_d;
      fast_q       <= fast_d;
      slow_q       <= slow_d;
      lost_q       <= lost_d;
      core_reset_q <= core_reset_d;
      ce_fast_q    <= ce_fast_d;
      ce_slow_q    <= ce_slow_d;
    end
  end

  assign core_reset      = core_reset_q;
  assign ce_fast         = ce_fast_q;
  assign ce_slow         = ce_slow_q;
  assign state           = state_q;
  assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_clk_reset_ctrl.sv
// Directed bench for clk_reset_ctrl: lock qualification, CE cadence, soft
// reset width, lock-loss priority/saturation and asynchronous reset.
module tb_clk_reset_ctrl;
  localparam int SYNC_STAGES        = 2;
  localparam int LOCK_STABLE_CYCLES = 16;
  localparam int RESET_HOLD_CYCLES  = 8;
  localparam int CE_DIV             = 4;
  localparam int SLOW_DIV           = 3;

  logic       clk_sys = 1'b0;
  logic       rst_n, pll_locked, soft_reset;
  logic       core_reset, ce_fast, ce_slow;
  logic [1:0] state;
  logic [7:0] lock_lost_count;

  int checks   = 0;
  int failures = 0;

  clk_reset_ctrl #(
    .SYNC_STAGES(SYNC_STAGES), .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .RESET_HOLD_CYCLES(RESET_HOLD_CYCLES), .CE_DIV(CE_DIV), .SLOW_DIV(SLOW_DIV)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pll_locked(pll_locked),
    .soft_reset(soft_reset), .core_reset(core_reset), .ce_fast(ce_fast),
    .ce_slow(ce_slow), .state(state), .lock_lost_count(lock_lost_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pll_locked = 1'b0; soft_reset = 1'b0;
    tick();
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if ({ce_fast, ce_slow} !== 2'b00) begin failures++; $display("FAIL rst_ce got=%b%b exp=00", ce_fast, ce_slow); end
    checks++; if (lock_lost_count !== 8'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", lock_lost_count); end
  endtask

  // Lock first sampled at edge 1: locked_s after edge 2, STABLE at 3, RUN at 19.
  task automatic test_power_up;
    int rel = 0, first_ce = 0;
    rst_n = 1'b1; pll_locked = 1'b1;
    for (int n = 1; n <= 40 && rel == 0; n++) begin
      tick();
      if (first_ce == 0 && ce_fast === 1'b1) first_ce = n;
      if (core_reset === 1'b0) rel = n;
    end
    checks++; if (rel != 19) begin failures++; $display("FAIL pwr_release_edge got=%0d exp=19", rel); end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL pwr_state got=%0d exp=3", state); end
    checks++; if (lock_lost_count !== 8'd0) begin failures++; $display("FAIL pwr_count got=%0d exp=0", lock_lost_count); end
    checks++; if (first_ce != 6) begin failures++; $display("FAIL pwr_first_ce_edge got=%0d exp=6", first_ce); end
  endtask

  task automatic test_ce_cadence;
    int nf = 0, ns = 0, orphan = 0, gap_bad = 0, last_f = 0, last_s = 0;
    for (int n = 1; n <= 48; n++) begin
      tick();
      if (ce_slow === 1'b1 && ce_fast !== 1'b1) orphan++;
      if (ce_fast === 1'b1) begin
        nf++;
        if (last_f != 0 && n - last_f != CE_DIV) gap_bad++;
        last_f = n;
      end
      if (ce_slow === 1'b1) begin
        ns++;
        if (last_s != 0 && n - last_s != CE_DIV * SLOW_DIV) gap_bad++;
        last_s = n;
      end
    end
    checks++; if (nf != 12) begin failures++; $display("FAIL ce_fast_pulses got=%0d exp=12", nf); end
    checks++; if (ns != 4) begin failures++; $display("FAIL ce_slow_pulses got=%0d exp=4", ns); end
    checks++; if (orphan != 0) begin failures++; $display("FAIL ce_slow_without_fast got=%0d exp=0", orphan); end
    checks++; if (gap_bad != 0) begin failures++; $display("FAIL ce_spacing got=%0d exp=0", gap_bad); end
  endtask

  // Span counts the cycle in which the request was sampled plus the
  // cycles core_reset is visibly high afterwards.
  task automatic test_soft_pulse;
    int high = 0, gap_bad = 0, last_f = 0;
    soft_reset = 1'b1;
    tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL softp_enter_hold got=%0d exp=2", state); end
    soft_reset = 1'b0;
    if (core_reset === 1'b1) high++;
    if (ce_fast === 1'b1) last_f = 1;
    for (int n = 2; n <= 24; n++) begin
      tick();
      if (core_reset === 1'b1 && state !== 2'd3) high++;
      if (ce_fast === 1'b1) begin
        if (last_f != 0 && n - last_f != CE_DIV) gap_bad++;
        last_f = n;
      end
    end
    checks++; if (high + 1 != RESET_HOLD_CYCLES + 1 + 1 - 1 + 0 && high + 1 != 9) begin failures++; $display("FAIL softp_span got=%0d exp=9", high + 1); end
    checks++; if (state !== 2'd3 || core_reset !== 1'b0) begin failures++; $display("FAIL softp_back_to_run got=%0d/%b exp=3/0", state, core_reset); end
    checks++; if (gap_bad != 0) begin failures++; $display("FAIL softp_ce_phase got=%0d exp=0", gap_bad); end
  endtask

  task automatic test_soft_held;
    int high = 0, gap_bad = 0, last_f = 0;
    soft_reset = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      tick();
      if (n == 20) soft_reset = 1'b0;
      if (core_reset === 1'b1) high++;
      if (ce_fast === 1'b1) begin
        if (last_f != 0 && n - last_f != CE_DIV) gap_bad++;
        last_f = n;
      end
    end
    checks++; if (high + 1 != 28) begin failures++; $display("FAIL softh_span got=%0d exp=28", high + 1); end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL softh_state got=%0d exp=3", state); end
    checks++; if (gap_bad != 0) begin failures++; $display("FAIL softh_ce_phase got=%0d exp=0", gap_bad); end
  endtask

  // soft_reset arrives on the very edge that sees locked_s=0.
  task automatic test_lock_loss;
    int stray = 0;
    pll_locked = 1'b0;
    tick(); tick();
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL loss_latency_early got=%0d exp=3", state); end
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL loss_state got=%0d exp=0", state); end
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL loss_core_reset got=%b exp=1", core_reset); end
    checks++; if ({ce_fast, ce_slow} !== 2'b00) begin failures++; $display("FAIL loss_ce got=%b%b exp=00", ce_fast, ce_slow); end
    checks++; if (lock_lost_count !== 8'd1) begin failures++; $display("FAIL loss_count got=%0d exp=1", lock_lost_count); end
    for (int n = 0; n < 8; n++) begin
      tick();
      if (ce_fast !== 1'b0 || ce_slow !== 1'b0 || state !== 2'd0) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL loss_quiet got=%0d exp=0", stray); end
  endtask

  task automatic test_saturate;
    int timeouts = 0;
    logic [7:0] at254 = 8'd0;
    for (int k = 0; k < 299; k++) begin
      pll_locked = 1'b1;
      for (int n = 0; n < 40 && state !== 2'd3; n++) tick();
      if (state !== 2'd3) timeouts++;
      pll_locked = 1'b0;
      tick(); tick(); tick();
      if (k == 252) at254 = lock_lost_count;
    end
    checks++; if (timeouts != 0) begin failures++; $display("FAIL sat_relock_timeout got=%0d exp=0", timeouts); end
    checks++; if (at254 !== 8'd254) begin failures++; $display("FAIL sat_count_254 got=%0d exp=254", at254); end
    checks++; if (lock_lost_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", lock_lost_count); end
  endtask

  task automatic test_async_reset_hold;
    pll_locked = 1'b1;
    for (int n = 0; n < 40 && state !== 2'd3; n++) tick();
    soft_reset = 1'b1;
    tick(); tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL arst_in_hold got=%0d exp=2", state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || core_reset !== 1'b1) begin failures++; $display("FAIL arst_state got=%0d/%b exp=0/1", state, core_reset); end
    checks++; if ({ce_fast, ce_slow} !== 2'b00) begin failures++; $display("FAIL arst_ce got=%b%b exp=00", ce_fast, ce_slow); end
    checks++; if (lock_lost_count !== 8'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", lock_lost_count); end
    soft_reset = 1'b0; pll_locked = 1'b0;
    tick();
  endtask

  // High at edges 1..10, low at 11..13, high again from edge 14:
  // WAIT_LOCK at 13, STABLE at 16, release at 14+18 = 32.
  task automatic test_lock_bounce;
    int rel = 0, saw_wait = 0;
    rst_n = 1'b0; pll_locked = 1'b0; soft_reset = 1'b0;
    tick();
    rst_n = 1'b1; pll_locked = 1'b1;
    for (int n = 1; n <= 60 && rel == 0; n++) begin
      tick();
      if (n == 10) pll_locked = 1'b0;
      if (n == 13) pll_locked = 1'b1;
      if (n > 3 && state === 2'd0) saw_wait++;
      if (core_reset === 1'b0) rel = n;
    end
    checks++; if (saw_wait == 0) begin failures++; $display("FAIL bounce_wait got=%0d exp=>0", saw_wait); end
    checks++; if (rel != 32) begin failures++; $display("FAIL bounce_release_edge got=%0d exp=32", rel); end
    checks++; if (lock_lost_count !== 8'd0) begin failures++; $display("FAIL bounce_count got=%0d exp=0", lock_lost_count); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_ce_cadence();
    test_soft_pulse();
    test_soft_held();
    test_lock_loss();
    test_saturate();
    test_async_reset_hold();
    test_lock_bounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
